stopwatch_fsm_ctrl: RTL and testbench

Parametrised stopwatch controller: a Moore FSM with stop, run, clear and lap modes, a clock prescaler, and a centisecond/second/minute time counter with carry and wrap. It sits between the debounced board switches/buttons and the seven-segment display driver. It replaces the fixed two-mode watch FSM with a configurable tick rate, minute range and an optional lap-freeze mode.

---
 rtl/stopwatch_fsm_ctrl_if.sv | 24 ++
 rtl/stopwatch_fsm_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_stopwatch_fsm_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_fsm_ctrl_if.sv
// Switch/button inputs and display/status outputs of the stopwatch controller.
// The slave side is the controller; the master side is whatever drives the switches.
interface stopwatch_fsm_ctrl_if;
   logic       sw_run;
   logic       btn_clr;
   logic       btn_lap;
   logic       o_run_on;
   logic       o_clr_on;
   logic       o_lap_on;
   logic [1:0] o_state;
   logic [6:0] o_csec;
   logic [5:0] o_sec;
   logic [5:0] o_min;

   modport master (
      output sw_run, btn_clr, btn_lap,
      input  o_run_on, o_clr_on, o_lap_on, o_state, o_csec, o_sec, o_min
   );

   modport slave (
      input  sw_run, btn_clr, btn_lap,
      output o_run_on, o_clr_on, o_lap_on, o_state, o_csec, o_sec, o_min
   );
endinterface

// File: rtl/stopwatch_fsm_ctrl.sv
// Stopwatch controller: Moore FSM (STOP/RUN/CLEAR/LAP), tick prescaler and min:sec.csec counter.
// Define STOPWATCH_LAP_EN to build the lap-freeze mode; without it LAP is unreachable.
module stopwatch_fsm_ctrl #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100,
   parameter int MAX_MIN = 59
) (
   input logic                 clk,
   input logic                 reset,
   stopwatch_fsm_ctrl_if.slave bus
);

   localparam int              DIV      = CLK_HZ / TICK_HZ;
   localparam int              PW       = $clog2(DIV);
   localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
   localparam logic [5:0]      MIN_LAST = 6'(MAX_MIN);

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10,
      ST_LAP   = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic            clr_q;
   logic            clr_rise;
   logic            counting;
   logic            tick;
   logic [PW-1:0]   pre_q, pre_d;
   logic [6:0]      csec_q, csec_d;
   logic [5:0]      sec_q, sec_d;
   logic [5:0]      min_q, min_d;
   logic [6:0]      disp_csec;
   logic [5:0]      disp_sec;
   logic [5:0]      disp_min;

   assign clr_rise = bus.btn_clr & ~clr_q;

`ifdef STOPWATCH_LAP_EN
   logic            lap_q;
   logic            lap_rise;
   logic [6:0]      lap_csec_q;
   logic [5:0]      lap_sec_q;
   logic [5:0]      lap_min_q;

   assign lap_rise = bus.btn_lap & ~lap_q;
   assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
`else
   logic            unused_btn_lap;

   assign unused_btn_lap = bus.btn_lap;
   assign counting       = (state_q == ST_RUN);
`endif

   assign tick = counting && (pre_q == PRE_LAST);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_STOP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (bus.sw_run) begin
               state_d = ST_RUN;
            end else if (clr_rise) begin
               state_d = ST_CLEAR;
            end
         end
         ST_RUN: begin
            if (!bus.sw_run) begin
               state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
            end else if (lap_rise) begin
               state_d = ST_LAP;
`endif
            end
         end
         ST_CLEAR: begin
            state_d = ST_STOP;
         end
         ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
            if (!bus.sw_run) begin
               state_d = ST_STOP;
            end else if (lap_rise) begin
               state_d = ST_RUN;
            end
`else
            // Code 11 is only reachable by an upset in this build; recover to STOP.
            state_d = ST_STOP;
`endif
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_comb begin
      pre_d  = pre_q;
      csec_d = csec_q;
      sec_d  = sec_q;
      min_d  = min_q;
      if (state_q == ST_CLEAR) begin
         pre_d  = '0;
         csec_d = '0;
         sec_d  = '0;
         min_d  = '0;
      end else if (counting) begin
         if (tick) begin
            pre_d = '0;
            // Cascaded carry: csec 99 -> sec, sec 59 -> min, min MAX_MIN -> 0.
            if (csec_q == 7'd99) begin
               csec_d = '0;
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == MIN_LAST) begin
                     min_d = '0;
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end else begin
               csec_d = csec_q + 7'd1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_q  <= 1'b0;
         pre_q  <= '0;
         csec_q <= '0;
         sec_q  <= '0;
         min_q  <= '0;
      end else begin
         clr_q  <= bus.btn_clr;
         pre_q  <= pre_d;
         csec_q <= csec_d;
         sec_q  <= sec_d;
         min_q  <= min_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   // Lap snapshot takes the pre-increment count even when a tick lands on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lap_q      <= 1'b0;
         lap_csec_q <= '0;
         lap_sec_q  <= '0;
         lap_min_q  <= '0;
      end else begin
         lap_q <= bus.btn_lap;
         if (state_q == ST_CLEAR) begin
            lap_csec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
         end else if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
            lap_csec_q <= csec_q;
            lap_sec_q  <= sec_q;
            lap_min_q  <= min_q;
         end
      end
   end
`endif

   // ------------------------------------------------------------ outputs
   always_comb begin
      disp_csec = csec_q;
      disp_sec  = sec_q;
      disp_min  = min_q;
`ifdef STOPWATCH_LAP_EN
      if (state_q == ST_LAP) begin
         disp_csec = lap_csec_q;
         disp_sec  = lap_sec_q;
         disp_min  = lap_min_q;
      end
`endif
   end

   assign bus.o_state  = state_q;
   assign bus.o_clr_on = (state_q == ST_CLEAR);
`ifdef STOPWATCH_LAP_EN
   assign bus.o_run_on = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign bus.o_lap_on = (state_q == ST_LAP);
`else
   assign bus.o_run_on = (state_q == ST_RUN);
   assign bus.o_lap_on = 1'b0;
`endif
   assign bus.o_csec   = disp_csec;
   assign bus.o_sec    = disp_sec;
   assign bus.o_min    = disp_min;

endmodule

// File: tb/tb_stopwatch_fsm_ctrl.sv
// Bench for stopwatch_fsm_ctrl: per-cycle expected outputs come from an elapsed-time model
// (single centisecond total, split with / and %) queued at stimulus time and popped by a monitor.
module tb_stopwatch_fsm_ctrl;

  localparam int CLK_HZ  = 4;
  localparam int TICK_HZ = 2;
  localparam int MAX_MIN = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int SPAN    = (MAX_MIN + 1) * 6000;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CLEAR = 2;
  localparam int M_LAP   = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       run_on;
    logic       clr_on;
    logic       lap_on;
    logic [6:0] csec;
    logic [5:0] sec;
    logic [5:0] min;
  } exp_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_fsm_ctrl_if bus ();

  stopwatch_fsm_ctrl #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .MAX_MIN(MAX_MIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------------------------------------------------------- model
  int   m_mode;
  int   m_pre;
  int   m_t;
  int   m_lap_t;
  bit   m_prev_clr;
  bit   m_prev_lap;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t mk(input int st, input int t);
    exp_t e;
    e.st     = 2'(st);
    e.run_on = (st == M_RUN) || (st == M_LAP);
    e.clr_on = (st == M_CLEAR);
    e.lap_on = (st == M_LAP);
    e.csec   = 7'(t % 100);
    e.sec    = 6'((t / 100) % 60);
    e.min    = 6'(t / 6000);
    return e;
  endfunction

  function automatic void model_reset();
    m_mode     = M_STOP;
    m_pre      = 0;
    m_t        = 0;
    m_lap_t    = 0;
    m_prev_clr = 1'b0;
    m_prev_lap = 1'b0;
  endfunction

  function automatic exp_t model_step(input bit run, input bit clr, input bit lap);
    bit clr_edge;
    bit lap_edge;
    int nxt;
    clr_edge = clr && !m_prev_clr;
    lap_edge = LAP_EN && lap && !m_prev_lap;
    nxt = m_mode;
    case (m_mode)
      M_STOP:  if (run) nxt = M_RUN; else if (clr_edge) nxt = M_CLEAR;
      M_RUN:   if (!run) nxt = M_STOP; else if (lap_edge) nxt = M_LAP;
      M_LAP:   if (!run) nxt = M_STOP; else if (lap_edge) nxt = M_RUN;
      default: nxt = M_STOP;
    endcase
    if (m_mode == M_RUN && nxt == M_LAP) m_lap_t = m_t;
    if (m_mode == M_CLEAR) begin
      m_pre   = 0;
      m_t     = 0;
      m_lap_t = 0;
    end else if (m_mode == M_RUN || m_mode == M_LAP) begin
      m_pre++;
      if (m_pre == DIV) begin
        m_pre = 0;
        m_t   = (m_t + 1) % SPAN;
      end
    end
    m_mode     = nxt;
    m_prev_clr = clr;
    m_prev_lap = lap;
    return mk(m_mode, (m_mode == M_LAP) ? m_lap_t : m_t);
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input bit run, input bit clr, input bit lap);
    @(negedge clk);
    bus.sw_run  = run;
    bus.btn_clr = clr;
    bus.btn_lap = lap;
    exp_q.push_back(model_step(run, clr, lap));
  endtask

  task automatic steps(input int n, input bit run, input bit clr, input bit lap);
    for (int i = 0; i < n; i++) step(run, clr, lap);
  endtask

  function automatic exp_t actual();
    exp_t a;
    a.st     = bus.o_state;
    a.run_on = bus.o_run_on;
    a.clr_on = bus.o_clr_on;
    a.lap_on = bus.o_lap_on;
    a.csec   = bus.o_csec;
    a.sec    = bus.o_sec;
    a.min    = bus.o_min;
    return a;
  endfunction

  function automatic void compare(input string name, input exp_t got, input exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got st=%0d run=%0b clr=%0b lap=%0b %0d:%0d.%0d, expected st=%0d run=%0b clr=%0b lap=%0b %0d:%0d.%0d",
               name, $time, got.st, got.run_on, got.clr_on, got.lap_on, got.min, got.sec, got.csec,
               want.st, want.run_on, want.clr_on, want.lap_on, want.min, want.sec, want.csec);
    end
  endfunction

  // Direct check against a constant, taken just after the edge that ended the last step.
  task automatic check_after_edge(input string name, input int st, input int t);
    @(posedge clk);
    #3;
    compare(name, actual(), mk(st, t));
  endtask

  // ---------------------------------------------------------------- scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("scoreboard", actual(), e);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit run_lvl;
    reset       = 1'b1;
    bus.sw_run  = 1'b0;
    bus.btn_clr = 1'b0;
    bus.btn_lap = 1'b0;
    model_reset();
    #1;
    compare("reset_state", actual(), mk(M_STOP, 0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Start, then 100 ticks -> 0:01.00
    step(1, 0, 0);
    steps(2 * 100, 1, 0, 0);
    check_after_edge("carry_csec_to_sec", M_RUN, 100);

    // Up to 1:59.99, then one more tick wraps to 0:00.00
    steps(2 * (SPAN - 1) - 200, 1, 0, 0);
    check_after_edge("max_before_wrap", M_RUN, SPAN - 1);
    steps(2, 1, 0, 0);
    check_after_edge("full_wrap", M_RUN, 0);

    // Stop mid-interval, hold, then clear pulse
    steps(7, 1, 0, 0);
    steps(4, 0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    check_after_edge("cleared_stop", M_STOP, 0);

    // sw_run and clr_rise together: run wins, counters untouched; held clear never re-fires
    step(1, 1, 0);
    check_after_edge("run_beats_clear", M_RUN, 0);
    steps(81, 1, 1, 0);
    steps(6, 0, 1, 0);
    step(0, 0, 0);

    // Clear, run to 0:00.42, then asynchronous reset between edges
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    steps(84, 1, 0, 0);
    check_after_edge("run_to_042", M_RUN, 42);
    reset = 1'b1;
    #1;
    compare("async_reset", actual(), mk(M_STOP, 0));
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0);

`ifdef STOPWATCH_LAP_EN
    // Lap freeze over 20 ticks, lap again to resume live, then lap and stop from LAP
    step(1, 0, 0);
    steps(10, 1, 0, 0);
    step(1, 0, 1);
    check_after_edge("lap_enter", M_LAP, 5);
    steps(39, 1, 0, 1);
    check_after_edge("lap_frozen", M_LAP, 5);
    step(1, 0, 0);
    step(1, 0, 1);
    check_after_edge("lap_exit_live", M_RUN, 26);
    steps(6, 1, 0, 0);
    step(1, 0, 1);
    steps(5, 1, 0, 0);
    step(0, 0, 0);
    steps(3, 0, 0, 0);
`endif

    // Randomized phase
    run_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) run_lvl = ~run_lvl;
      step(run_lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    // Drain and report
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
